// File: rtl/hdmi_overlay_pkg.sv
// Shared constants for the HDMI channel-number overlay: glyph geometry,
// text colours and the per-channel background palette.
package hdmi_overlay_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 12;

  localparam rgb_t TEXT_WHITE  = 24'hFF_FF_FF;
  localparam rgb_t TEXT_YELLOW = 24'hFF_FF_00;

  // Background colour shown behind the digit for each channel.
  localparam rgb_t PALETTE [8] = '{
    24'hC8_6E_3C, 24'h20_40_A0, 24'h30_90_30, 24'h80_20_80,
    24'h10_70_70, 24'h60_60_60, 24'hA0_20_20, 24'h00_00_80
  };

endpackage

// File: rtl/hdmi_glyph_rom.sv
// 8x12 bitmap font for digits '1'..'8' (digit index 0 selects '1').
// Registered output: pixel reflects the address presented one cycle earlier.
module hdmi_glyph_rom
  import hdmi_overlay_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] digit,
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic       pixel
);

  // Each byte is one glyph row; bit 7 is the leftmost column.
  localparam logic [7:0] FONT [8][12] = '{
    '{8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h7E, 8'h00, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00},
    '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00},
    '{8'h00, 8'h7E, 8'h60, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00},
    '{8'h00, 8'h3C, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00},
    '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00},
    '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00}
  };

  logic [7:0] row_bits;
  logic       pixel_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    row_bits = '0;
    if (row < 4'(GLYPH_H)) row_bits = FONT[digit][row];
  end

  // NOTE: the font is a constant table, so only the output register needs a reset.
  always_ff @(posedge clk) begin
    if (rst) pixel_q <= 1'b0;
    else     pixel_q <= row_bits[~col];
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/hdmi_channel_overlay.sv
// Overlays the active channel number as a magnified digit on the video stream,
// with a per-channel background and a timed yellow highlight after a switch.
module hdmi_channel_overlay
  import hdmi_overlay_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SCALE_SHIFT = 2,
  parameter int TEXT_X0     = 0,
  parameter int TEXT_Y0     = 0,
  parameter int HL_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] px_x,
  input  logic [11:0] px_y,
  input  logic        data_en,
  input  logic        frame_start,
  input  logic [2:0]  channel_select,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de_out,
  output logic [2:0]  active_ch
);

  logic [2:0] active_ch_q, active_ch_d;
  logic [7:0] hl_q, hl_d;
  logic       par_q, par_d;
  logic       sel_ok;

  // Channel switches only at frame_start; the highlight counter steps down
  // on every second frame_start, and a reload restarts that cadence.
  always_comb begin
    sel_ok      = frame_start && ({1'b0, channel_select} < 4'(NUM_CH));
    active_ch_d = active_ch_q;
    hl_d        = hl_q;
    par_d       = par_q;
    if (frame_start) par_d = ~par_q;
    if (frame_start && par_q && hl_q != 8'd0) hl_d = hl_q - 8'd1;
    if (sel_ok) begin
      active_ch_d = channel_select;
      if (channel_select != active_ch_q) begin
        hl_d  = 8'(HL_FRAMES);
        par_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_ch_q <= '0;
      hl_q        <= '0;
      par_q       <= 1'b0;
    end else begin
      active_ch_q <= active_ch_d;
      hl_q        <= hl_d;
      par_q       <= par_d;
    end
  end

  // Stage 1: window test and glyph-cell address; the compare on px_x/px_y
  // guards against the unsigned subtraction wrapping left/above the origin.
  logic [11:0] dx, dy, gx, gy;
  logic        in_win;

  always_comb begin
    dx     = px_x - 12'(TEXT_X0);
    dy     = px_y - 12'(TEXT_Y0);
    gx     = dx >> SCALE_SHIFT;
    gy     = dy >> SCALE_SHIFT;
    in_win = (px_x >= 12'(TEXT_X0)) && (px_y >= 12'(TEXT_Y0)) &&
             (gx < 12'(GLYPH_W)) && (gy < 12'(GLYPH_H));
  end

  logic text_bit;

  hdmi_glyph_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .digit (active_ch_q),
    .row   (gy[3:0]),
    .col   (gx[2:0]),
    .pixel (text_bit)
  );

  logic       de1_q, win1_q, hl1_q;
  logic [2:0] ch1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      de1_q  <= 1'b0;
      win1_q <= 1'b0;
      hl1_q  <= 1'b0;
      ch1_q  <= '0;
    end else begin
      de1_q  <= data_en;
      win1_q <= in_win;
      hl1_q  <= (hl_q != 8'd0);
      ch1_q  <= active_ch_q;
    end
  end

  // Stage 2: colour mux into the output registers.
  rgb_t rgb_d, rgb_q;
  logic de_out_q;

  always_comb begin
    rgb_d = '0;
    if (de1_q) begin
      if (win1_q && text_bit) rgb_d = hl1_q ? TEXT_YELLOW : TEXT_WHITE;
      else                    rgb_d = PALETTE[ch1_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      de_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= de1_q;
    end
  end

  assign r         = rgb_q.r;
  assign g         = rgb_q.g;
  assign b         = rgb_q.b;
  assign de_out    = de_out_q;
  assign active_ch = active_ch_q;

endmodule
